// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified memory port arbiter.
// Holds the arbiter state encoding and the read-return owner tags.
package mem_arb_pkg;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 32;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_D
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and RAM bus bundle for the arbiter.
// master = cpu/RAM side, slave = arbiter side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        output ram_q,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_wren, ram_data
    );

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        input  ram_q,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_wren, ram_data
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep owner-tag shift register with synchronous clear.
// The tail tag selects which requester sees the RAM output as valid.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output logic    if_rvalid,
    output logic    d_rvalid
);

    rd_tag_t tags [RD_LAT];

    // shift each cycle's owner tag along in step with the RAM read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) tags[i] <= TAG_NONE;
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    // in-flight reads are dropped while reset is held
    assign if_rvalid = rst_n && (tags[RD_LAT-1] == TAG_IF);
    assign d_rvalid  = rst_n && (tags[RD_LAT-1] == TAG_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data paths.
// Optional fetch anti-starvation boost: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output logic               locked
);

    arb_state_t state;
    rd_tag_t    tag_in;
    logic       boost;
    logic       if_gnt;
    logic       d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign boost = (state == IDLE) && (starve_cnt >= CW'(STARVE_LIMIT));

    // count consecutive denied fetch cycles; grant, no request or lock restart it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == LOCKED || !bus.if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (!boost) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign boost = 1'b0;
`endif

    assign d_gnt  = rst_n & bus.d_req & ~boost;
    assign if_gnt = rst_n & bus.if_req &
                    (boost | (~bus.d_req & (state == IDLE)));

    assign bus.d_gnt    = d_gnt;
    assign bus.if_gnt   = if_gnt;
    assign bus.if_rdata = bus.ram_q;
    assign bus.d_rdata  = bus.ram_q;

    // steer the granted requester onto the RAM and tag reads by owner
    always_comb begin
        bus.ram_addr = {AW{1'b0}};
        bus.ram_wren = 1'b0;
        bus.ram_data = {DW{1'b0}};
        tag_in       = TAG_NONE;
        unique case (1'b1)
            d_gnt: begin
                bus.ram_addr = bus.d_addr;
                bus.ram_wren = bus.d_we;
                bus.ram_data = bus.d_wdata;
                tag_in       = bus.d_we ? TAG_NONE : TAG_D;
            end
            if_gnt: begin
                bus.ram_addr = bus.if_addr;
                tag_in       = TAG_IF;
            end
            default: ;
        endcase
    end

    // lock FSM: data side keeps the port across a multi-word transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            locked <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_gnt && bus.d_lock) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (d_gnt && !bus.d_lock) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end
            endcase
        end
    end

    rd_tag_pipe #(
        .RD_LAT    (RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (tag_in),
        .if_rvalid (bus.if_rvalid),
        .d_rvalid  (bus.d_rvalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-return scoreboard.
// Grants are checked per step; read data is popped by a separate monitor.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic locked;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(7), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW           (7),
        .DW           (32),
        .RD_LAT       (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .locked (locked)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // RAM model, 1-cycle read latency, preloaded mem[a] = a*4
    logic [31:0] mem [128];
    logic [31:0] q_r = 32'h0;

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        q_r <= mem[bus.ram_addr];
    end

    assign bus.ram_q = q_r;

    // scoreboard entries: {owner is data side, expected data}
    logic [32:0] sb [$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected rvalid: got if=%b d=%b want none",
                         bus.if_rvalid, bus.d_rvalid);
            end else begin
                e = sb.pop_front();
                chk("rvalid owner", 32'({bus.d_rvalid, bus.if_rvalid}),
                    e[32] ? 32'h2 : 32'h1);
                chk("rdata", e[32] ? bus.d_rdata : bus.if_rdata, e[31:0]);
            end
        end
    end

    task automatic step(
        input string      nm,
        input logic       ir,
        input logic [6:0] ia,
        input logic       dr,
        input logic       dw,
        input logic       dl,
        input logic [6:0] da,
        input logic [31:0] wd,
        input logic       eig,
        input logic       edg,
        input logic [6:0] ea,
        input logic       ewe,
        input logic       elk,
        input logic [31:0] ed,
        input bit         push = 1'b1
    );
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_lock  = dl;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        @(negedge clk);
        chk({nm, " if_gnt"}, 32'(bus.if_gnt), 32'(eig));
        chk({nm, " d_gnt"}, 32'(bus.d_gnt), 32'(edg));
        chk({nm, " ram_addr"}, 32'(bus.ram_addr), 32'(ea));
        chk({nm, " ram_wren"}, 32'(bus.ram_wren), 32'(ewe));
        chk({nm, " locked"}, 32'(locked), 32'(elk));
        if (push && eig) sb.push_back({1'b0, ed});
        if (push && edg && !dw) sb.push_back({1'b1, ed});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i * 4);
        bus.if_req  = 1'b1;
        bus.if_addr = 7'h10;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_lock  = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // reset with a pending fetch: nothing granted or valid
        repeat (2) begin
            @(negedge clk);
            chk("rst if_gnt", 32'(bus.if_gnt), 0);
            chk("rst d_gnt", 32'(bus.d_gnt), 0);
            chk("rst rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 0);
            chk("rst ram_wren", 32'(bus.ram_wren), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("release", 1, 7'h00, 0, 0, 0, 0, 0, 1, 0, 7'h00, 0, 0, 32'h0);

        // simultaneous: data wins
        step("simul", 1, 7'h10, 1, 0, 0, 7'h20, 0, 0, 1, 7'h20, 0, 0, 32'h80);
        step("if_after", 1, 7'h10, 0, 0, 0, 0, 0, 1, 0, 7'h10, 0, 0, 32'h40);

        // pipelined alternation
        step("alt0", 1, 7'h01, 0, 0, 0, 0, 0, 1, 0, 7'h01, 0, 0, 32'h04);
        step("alt1", 0, 7'h00, 1, 0, 0, 7'h02, 0, 0, 1, 7'h02, 0, 0, 32'h08);
        step("alt2", 1, 7'h03, 0, 0, 0, 0, 0, 1, 0, 7'h03, 0, 0, 32'h0C);

        // locked write, idle, unlocking read
        step("lk_wr", 1, 7'h07, 1, 1, 1, 7'h05, 32'hDEADBEEF,
             0, 1, 7'h05, 1, 0, 0);
        step("lk_idle0", 1, 7'h07, 0, 0, 0, 0, 0, 0, 0, 7'h00, 0, 1, 0);
        step("lk_idle1", 1, 7'h07, 0, 0, 0, 0, 0, 0, 0, 7'h00, 0, 1, 0);
        step("lk_rd", 1, 7'h07, 1, 0, 0, 7'h05, 0,
             0, 1, 7'h05, 0, 1, 32'hDEADBEEF);
        step("unlocked", 1, 7'h07, 0, 0, 0, 0, 0, 1, 0, 7'h07, 0, 0, 32'h1C);

        // write then read the same word
        step("wr09", 0, 0, 1, 1, 0, 7'h09, 32'h12345678, 0, 1, 7'h09, 1, 0, 0);
        step("rd09", 0, 0, 1, 0, 0, 7'h09, 0, 0, 1, 7'h09, 0, 0, 32'h12345678);
        idle("idle0");
        idle("idle1");

        // reset one cycle after a fetch grant: its data never returns
        step("rst_rd", 1, 7'h04, 0, 0, 0, 0, 0, 1, 0, 7'h04, 0, 0, 0, 1'b0);
        rst_n = 1'b0;
        bus.if_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid if_rvalid", 32'(bus.if_rvalid), 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle("post_rst");
        idle("post_rst1");

        // both requesters held: fetch only gets in with the starve guard
        for (int k = 0; k < 10; k++) begin
            logic g;
            g = GUARD && (k % 5 == 4);
            step("starve", 1, 7'h11, 1, 0, 0, 7'h22, 0, g, !g,
                 g ? 7'h11 : 7'h22, 0, 0, g ? 32'h44 : 32'h88);
        end

        idle("drain0");
        idle("drain1");
        chk("sb empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
